hand_frame_sched: RTL

Frame-level controller for the hand-signal colour-zone detector. Converts a raw pixel-valid stream with SOF/EOL markers into pixel coordinates, a zone_id and per-frame clear/latch strobes. Captures the detector's per-frame blue/red winning zones after a pipeline drain. Adds a multi-frame stability qualifier and hands results downstream over a valid/ready handshake.

---
 rtl/hand_frame_sched_pkg.sv | 27 ++
 rtl/hand_frame_sched_if.sv | 47 ++++
 rtl/hand_frame_sched_zone_counter.sv | 72 +++++++
 rtl/hand_frame_sched.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/hand_frame_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hand_sig_pkg
//  Brief    : Shared defaults, widths and FSM state type for the hand-signal
//             frame scheduler.
//  Revision : 1.0  initial release
// ============================================================================
package hand_sig_pkg;

    localparam int IMG_WIDTH_DEF  = 1920;
    localparam int IMG_HEIGHT_DEF = 1080;
    localparam int NX_DEF         = 10;
    localparam int NY_DEF         = 8;

    localparam int IMG_WB = $clog2(IMG_WIDTH_DEF);
    localparam int IMG_HB = $clog2(IMG_HEIGHT_DEF);
    localparam int ZB     = $clog2(NX_DEF * NY_DEF);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        LATCH  = 2'd3
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/hand_frame_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : hand_frame_sched_if
//  Brief    : Pixel stream, detector and result handshake bundle of the
//             frame scheduler. slave = scheduler view, master = environment.
//  Revision : 1.0  initial release
// ============================================================================
interface hand_frame_sched_if
    import hand_sig_pkg::*;
#(
    parameter int IMG_WB_P = IMG_WB,
    parameter int IMG_HB_P = IMG_HB,
    parameter int ZB_P     = ZB
) ();
    logic                pix_valid;
    logic                sof;
    logic                eol;
    logic [IMG_WB_P-1:0] x_pixel;
    logic [IMG_HB_P-1:0] y_pixel;
    logic [ZB_P-1:0]     zone_id;
    logic                frame_clr;
    logic                frame_latch;
    logic [ZB_P-1:0]     det_blue_zone;
    logic [ZB_P-1:0]     det_red_zone;
    logic                res_valid;
    logic                res_ready;
    logic [ZB_P-1:0]     res_blue_zone;
    logic [ZB_P-1:0]     res_red_zone;
    logic                res_stable;
    logic                res_overrun;
    logic                frame_err;

    modport slave (
        input  pix_valid, sof, eol, det_blue_zone, det_red_zone, res_ready,
        output x_pixel, y_pixel, zone_id, frame_clr, frame_latch,
               res_valid, res_blue_zone, res_red_zone, res_stable,
               res_overrun, frame_err
    );

    modport master (
        output pix_valid, sof, eol, det_blue_zone, det_red_zone, res_ready,
        input  x_pixel, y_pixel, zone_id, frame_clr, frame_latch,
               res_valid, res_blue_zone, res_red_zone, res_stable,
               res_overrun, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/hand_frame_sched_zone_counter.sv
`default_nettype none
// ============================================================================
//  Module   : hand_zone_counter
//  Brief    : Saturating position counter with a divider-free zone index.
//             clr restarts the count at 0 in the same cycle (the presented
//             position is already 0); zero forces the next value to 0.
//  Revision : 1.0  initial release
// ============================================================================
module hand_zone_counter #(
    parameter int LEN  = 1920,
    parameter int NSEG = 10,
    parameter int PW   = (LEN  > 1) ? $clog2(LEN)  : 1,
    parameter int ZW   = (NSEG > 1) ? $clog2(NSEG) : 1
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          clr,
    input  logic          zero,
    input  logic          inc,
    output logic [PW-1:0] pos,
    output logic [ZW-1:0] zone,
    output logic          at_max
);
    localparam int SEG = LEN / NSEG;
    localparam int SW  = (SEG > 1) ? $clog2(SEG) : 1;

    logic [PW-1:0] pos_q, pos_d, pos_base;
    logic [SW-1:0] seg_q, seg_d, seg_base;
    logic [ZW-1:0] zone_q, zone_d, zone_base;

    assign pos_base  = clr ? '0 : pos_q;
    assign seg_base  = clr ? '0 : seg_q;
    assign zone_base = clr ? '0 : zone_q;

    assign pos    = pos_base;
    assign zone   = zone_base;
    assign at_max = (pos_base == PW'(LEN - 1));

    // Next position: advance with segment wrap, hold at the last position.
    always_comb begin
        pos_d  = pos_base;
        seg_d  = seg_base;
        zone_d = zone_base;
        if (zero) begin
            pos_d  = '0;
            seg_d  = '0;
            zone_d = '0;
        end else if (inc && !at_max) begin
            pos_d = pos_base + 1'b1;
            if (seg_base == SW'(SEG - 1)) begin
                seg_d  = '0;
                zone_d = zone_base + 1'b1;
            end else begin
                seg_d = seg_base + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            pos_q  <= '0;
            seg_q  <= '0;
            zone_q <= '0;
        end else begin
            pos_q  <= pos_d;
            seg_q  <= seg_d;
            zone_q <= zone_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/hand_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module   : hand_frame_sched
//  Brief    : Frame controller: pixel coordinates and zone, clear/latch
//             strobes, result capture with stability qualifier, valid/ready
//             result hand-off, sticky overrun and framing error flags.
//             Optional macro HAND_SCHED_ERRCNT_EN adds a 16-bit saturating
//             err_cnt output counting framing error events.
//  Revision : 1.0  initial release
// ============================================================================
module hand_frame_sched
    import hand_sig_pkg::*;
#(
    parameter int IMG_WIDTH     = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT    = IMG_HEIGHT_DEF,
    parameter int NX            = NX_DEF,
    parameter int NY            = NY_DEF,
    parameter int DRAIN_CYC     = 4,
    parameter int STABLE_FRAMES = 3
) (
    input  logic              pclk,
    input  logic              rst,
`ifdef HAND_SCHED_ERRCNT_EN
    output logic [15:0]       err_cnt,
`endif
    hand_frame_sched_if.slave bus
);
    localparam int XW  = $clog2(IMG_WIDTH);
    localparam int YW  = $clog2(IMG_HEIGHT);
    localparam int ZW  = $clog2(NX * NY);
    localparam int ZXW = (NX > 1) ? $clog2(NX) : 1;
    localparam int ZYW = (NY > 1) ? $clog2(NY) : 1;
    localparam int DW  = $clog2(DRAIN_CYC + 1);
    localparam int SW  = (STABLE_FRAMES > 1) ? $clog2(STABLE_FRAMES) : 1;

    sched_state_t  state_q, state_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic [ZW-1:0] res_blue_q, res_blue_d, res_red_q, res_red_d;
    logic [SW-1:0] stab_cnt_q, stab_cnt_d, stab_nxt;
    logic          res_valid_q, res_valid_d, res_stable_q, res_stable_d;
    logic          res_overrun_q, res_overrun_d, frame_err_q, frame_err_d;
    logic          have_prev_q, have_prev_d;

    logic           start, pix_acc, eol_acc, last_line, err_ev, same_zones;
    logic           x_at_max, y_at_max;
    logic [XW-1:0]  x_pos;
    logic [YW-1:0]  y_pos;
    logic [ZXW-1:0] zx;
    logic [ZYW-1:0] zy;

    // A sof pixel starts a frame from any state except the latch cycle.
    assign start     = bus.pix_valid && bus.sof && (state_q != LATCH);
    assign pix_acc   = bus.pix_valid && (start || state_q == ACTIVE);
    assign eol_acc   = pix_acc && bus.eol;
    assign last_line = eol_acc && y_at_max;
    assign err_ev    = (start && (state_q == ACTIVE || state_q == DRAIN))
                     || (eol_acc && !x_at_max)
                     || (pix_acc && !bus.eol && x_at_max);

    hand_zone_counter #(.LEN(IMG_WIDTH), .NSEG(NX), .PW(XW), .ZW(ZXW)) u_col (
        .pclk(pclk), .rst(rst), .clr(start), .zero(eol_acc),
        .inc(pix_acc && !bus.eol), .pos(x_pos), .zone(zx), .at_max(x_at_max)
    );

    hand_zone_counter #(.LEN(IMG_HEIGHT), .NSEG(NY), .PW(YW), .ZW(ZYW)) u_row (
        .pclk(pclk), .rst(rst), .clr(start), .zero(last_line),
        .inc(eol_acc), .pos(y_pos), .zone(zy), .at_max(y_at_max)
    );

    assign same_zones = have_prev_q && (bus.det_blue_zone == res_blue_q)
                                    && (bus.det_red_zone  == res_red_q);
    assign stab_nxt   = !same_zones ? '0 :
                        (stab_cnt_q == SW'(STABLE_FRAMES - 1)) ? stab_cnt_q :
                        stab_cnt_q + 1'b1;

    assign bus.x_pixel       = x_pos;
    assign bus.y_pixel       = y_pos;
    assign bus.zone_id       = ZW'(ZW'(zy) * ZW'(NX) + ZW'(zx));
    assign bus.frame_clr     = start;
    assign bus.frame_latch   = (state_q == LATCH);
    assign bus.res_valid     = res_valid_q;
    assign bus.res_blue_zone = res_blue_q;
    assign bus.res_red_zone  = res_red_q;
    assign bus.res_stable    = res_stable_q;
    assign bus.res_overrun   = res_overrun_q;
    assign bus.frame_err     = frame_err_q;

    // Frame sequencing, result capture and downstream handshake.
    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = '0;
        res_valid_d   = res_valid_q;
        res_blue_d    = res_blue_q;
        res_red_d     = res_red_q;
        res_stable_d  = res_stable_q;
        res_overrun_d = res_overrun_q;
        frame_err_d   = frame_err_q || err_ev;
        stab_cnt_d    = stab_cnt_q;
        have_prev_d   = have_prev_q;
        if (res_valid_q && bus.res_ready) res_valid_d = 1'b0;
        case (state_q)
            IDLE:   if (start) state_d = last_line ? DRAIN : ACTIVE;
            ACTIVE: if (last_line) state_d = DRAIN;
            DRAIN: begin
                if (start)                                   state_d = last_line ? DRAIN : ACTIVE;
                else if (drain_cnt_q == DW'(DRAIN_CYC - 1)) state_d = LATCH;
                else                                         drain_cnt_d = drain_cnt_q + 1'b1;
            end
            LATCH: begin
                state_d      = IDLE;
                res_blue_d   = bus.det_blue_zone;
                res_red_d    = bus.det_red_zone;
                res_valid_d  = 1'b1;
                stab_cnt_d   = stab_nxt;
                res_stable_d = (stab_nxt == SW'(STABLE_FRAMES - 1));
                have_prev_d  = 1'b1;
                // A simultaneous accept consumes the old result: not an overrun.
                if (res_valid_q && !bus.res_ready) res_overrun_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            drain_cnt_q   <= '0;
            res_valid_q   <= 1'b0;
            res_blue_q    <= '0;
            res_red_q     <= '0;
            res_stable_q  <= 1'b0;
            res_overrun_q <= 1'b0;
            frame_err_q   <= 1'b0;
            stab_cnt_q    <= '0;
            have_prev_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            res_valid_q   <= res_valid_d;
            res_blue_q    <= res_blue_d;
            res_red_q     <= res_red_d;
            res_stable_q  <= res_stable_d;
            res_overrun_q <= res_overrun_d;
            frame_err_q   <= frame_err_d;
            stab_cnt_q    <= stab_cnt_d;
            have_prev_q   <= have_prev_d;
        end
    end

`ifdef HAND_SCHED_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // Saturating count of framing error events.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_ev && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end

    // Error counter register.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif
endmodule
`default_nettype wire
